// File: rtl/edge_stream_tx_pkg.sv
// Shared definitions for the edge-record stream source: default widths and walker states.
package edge_stream_tx_pkg;

    localparam int DEF_NODE_IDX_WIDTH  = 10;
    localparam int DEF_COUNTER_WIDTH   = 4;
    localparam int DEF_EDGE_ADDR_WIDTH = 12;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_NODE = 3'd1,
        ST_LOAD_NODE  = 3'd2,
        ST_FETCH_EDGE = 3'd3,
        ST_CAPTURE    = 3'd4,
        ST_SEND       = 3'd5,
        ST_FINISH     = 3'd6
    } state_e;

endpackage

// File: rtl/edge_stream_tx_if.sv
// Edge-record stream: one (node, successor, remaining-count) record per valid/ready transfer.
interface edge_stream_tx_if
    import edge_stream_tx_pkg::*;
#(
    parameter int NODE_IDX_WIDTH = DEF_NODE_IDX_WIDTH,
    parameter int COUNTER_WIDTH  = DEF_COUNTER_WIDTH
) ();

    logic                      out_valid;
    logic                      out_ready;
    logic [NODE_IDX_WIDTH-1:0] node_idx;
    logic [NODE_IDX_WIDTH-1:0] next_node_idx;
    logic [COUNTER_WIDTH-1:0]  next_node_counter;

    modport master (
        output out_valid,
        output node_idx,
        output next_node_idx,
        output next_node_counter,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  node_idx,
        input  next_node_idx,
        input  next_node_counter,
        output out_ready
    );

endinterface

// File: rtl/edge_stream_tx.sv
// Walks the node/edge ROMs in ascending node order and emits one stream record per edge.
module edge_stream_tx
    import edge_stream_tx_pkg::*;
#(
    parameter int PARAM_NODE_IDX_WIDTH  = DEF_NODE_IDX_WIDTH,
    parameter int PARAM_COUNTER_WIDTH   = DEF_COUNTER_WIDTH,
    parameter int PARAM_EDGE_ADDR_WIDTH = DEF_EDGE_ADDR_WIDTH
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 start_run,
    input  logic [PARAM_NODE_IDX_WIDTH:0]                        num_nodes,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]                      node_tbl_addr,
    input  logic [PARAM_EDGE_ADDR_WIDTH+PARAM_COUNTER_WIDTH-1:0] node_tbl_rdata,
    output logic [PARAM_EDGE_ADDR_WIDTH-1:0]                     edge_tbl_addr,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]                      edge_tbl_rdata,
    edge_stream_tx_if.master                                     rec,
    output logic                                                 busy,
    output logic                                                 done
);

    localparam int NW = PARAM_NODE_IDX_WIDTH;
    localparam int CW = PARAM_COUNTER_WIDTH;
    localparam int EA = PARAM_EDGE_ADDR_WIDTH;

    localparam logic [NW:0]   NUM_ONE  = (NW+1)'(1);
    localparam logic [NW-1:0] NODE_ONE = NW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        state_r,      state_next_s;
    logic [NW:0]   num_nodes_r,  num_nodes_s;
    logic [NW-1:0] cur_node_r,   cur_node_s;
    logic [EA-1:0] edge_base_r,  edge_base_s;
    logic [CW-1:0] edge_count_r, edge_count_s;
    logic [CW-1:0] k_r,          k_s;
    logic [EA-1:0] edge_addr_r,  edge_addr_s;
    logic [NW-1:0] node_idx_r,   node_idx_s;
    logic [NW-1:0] next_idx_r,   next_idx_s;
    logic [CW-1:0] next_cnt_r,   next_cnt_s;
    logic          out_valid_r,  out_valid_s;
    logic          busy_r,       busy_s;
    logic          done_r,       done_s;

    logic [CW-1:0] k_inc_s;
    logic          last_node_s;

    // Compared at NW+1 bits so a full 2**NW-node walk terminates on node 2**NW-1.
    assign last_node_s = ({1'b0, cur_node_r} == (num_nodes_r - NUM_ONE));
    assign k_inc_s     = k_r + CNT_ONE;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and next-value logic for the walk.
    always_comb begin
        state_next_s = state_r;
        num_nodes_s  = num_nodes_r;
        cur_node_s   = cur_node_r;
        edge_base_s  = edge_base_r;
        edge_count_s = edge_count_r;
        k_s          = k_r;
        edge_addr_s  = edge_addr_r;
        node_idx_s   = node_idx_r;
        next_idx_s   = next_idx_r;
        next_cnt_s   = next_cnt_r;
        busy_s       = busy_r;
        done_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // busy is still high during the done cycle, which also swallows any start.
                if (busy_r) begin
                    busy_s = 1'b0;
                end else if (start_run) begin
                    num_nodes_s = num_nodes;
                    cur_node_s  = '0;
                    busy_s      = 1'b1;
                    if (num_nodes == '0) begin
                        state_next_s = ST_FINISH;
                    end else begin
                        state_next_s = ST_FETCH_NODE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH_NODE: begin
                state_next_s = ST_LOAD_NODE;
            end
            ST_LOAD_NODE: begin
                edge_base_s  = node_tbl_rdata[EA+CW-1 -: EA];
                edge_count_s = node_tbl_rdata[CW-1:0];
                k_s          = '0;
                if (node_tbl_rdata[CW-1:0] != '0) begin
                    edge_addr_s  = node_tbl_rdata[EA+CW-1 -: EA];
                    state_next_s = ST_FETCH_EDGE;
                end else if (last_node_s) begin
                    state_next_s = ST_FINISH;
                end else begin
                    cur_node_s   = cur_node_r + NODE_ONE;
                    state_next_s = ST_FETCH_NODE;
                end
            end
            ST_FETCH_EDGE: begin
                state_next_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                node_idx_s   = cur_node_r;
                next_idx_s   = edge_tbl_rdata;
                next_cnt_s   = edge_count_r - k_inc_s;
                state_next_s = ST_SEND;
            end
            ST_SEND: begin
                if (rec.out_ready) begin
                    k_s = k_inc_s;
                    if (k_inc_s < edge_count_r) begin
                        edge_addr_s  = edge_base_r + EA'(k_inc_s);
                        state_next_s = ST_FETCH_EDGE;
                    end else if (last_node_s) begin
                        state_next_s = ST_FINISH;
                    end else begin
                        cur_node_s   = cur_node_r + NODE_ONE;
                        state_next_s = ST_FETCH_NODE;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_FINISH: begin
                done_s       = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                busy_s       = 1'b0;
            end
        endcase

        out_valid_s = (state_next_s == ST_SEND);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_nodes_r  <= '0;
            cur_node_r   <= '0;
            edge_base_r  <= '0;
            edge_count_r <= '0;
            k_r          <= '0;
            edge_addr_r  <= '0;
            node_idx_r   <= '0;
            next_idx_r   <= '0;
            next_cnt_r   <= '0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            num_nodes_r  <= num_nodes_s;
            cur_node_r   <= cur_node_s;
            edge_base_r  <= edge_base_s;
            edge_count_r <= edge_count_s;
            k_r          <= k_s;
            edge_addr_r  <= edge_addr_s;
            node_idx_r   <= node_idx_s;
            next_idx_r   <= next_idx_s;
            next_cnt_r   <= next_cnt_s;
            out_valid_r  <= out_valid_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign node_tbl_addr         = cur_node_r;
    assign edge_tbl_addr         = edge_addr_r;
    assign rec.out_valid         = out_valid_r;
    assign rec.node_idx          = node_idx_r;
    assign rec.next_node_idx     = next_idx_r;
    assign rec.next_node_counter = next_cnt_r;
    assign busy                  = busy_r;
    assign done                  = done_r;

endmodule

// File: tb/tb_edge_stream_tx.sv
// Directed bench for edge_stream_tx with a 1-cycle synchronous-read adjacency ROM model.
module tb_edge_stream_tx;
    import edge_stream_tx_pkg::*;

    localparam int NW = 10;
    localparam int CW = 4;
    localparam int EA = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_run;
    logic [NW:0]   num_nodes;
    logic [NW-1:0] node_tbl_addr;
    logic [EA+CW-1:0] node_tbl_rdata;
    logic [EA-1:0] edge_tbl_addr;
    logic [NW-1:0] edge_tbl_rdata;
    logic          busy;
    logic          done;

    edge_stream_tx_if #(.NODE_IDX_WIDTH(NW), .COUNTER_WIDTH(CW)) bus ();

    edge_stream_tx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_run      (start_run),
        .num_nodes      (num_nodes),
        .node_tbl_addr  (node_tbl_addr),
        .node_tbl_rdata (node_tbl_rdata),
        .edge_tbl_addr  (edge_tbl_addr),
        .edge_tbl_rdata (edge_tbl_rdata),
        .rec            (bus.master),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Adjacency ROMs with one-cycle synchronous read.
    logic [EA+CW-1:0] node_rom [0:1023];
    logic [NW-1:0]    edge_rom [0:4095];
    always @(posedge clk) begin
        node_tbl_rdata <= node_rom[node_tbl_addr];
        edge_tbl_rdata <= edge_rom[edge_tbl_addr];
    end

    // Sink ready: fixed level or accept one cycle in three.
    logic       ready_mode = 1'b0;
    logic       ready_fix  = 1'b0;
    logic [1:0] rdy_cnt    = 2'd0;
    always @(negedge clk) rdy_cnt <= (rdy_cnt == 2'd2) ? 2'd0 : rdy_cnt + 2'd1;
    assign bus.out_ready = ready_mode ? (rdy_cnt == 2'd0) : ready_fix;

    // Stream monitor: transfer log, stall stability and node-address sweep.
    wire [23:0]  cur_rec = {bus.node_idx, bus.next_node_idx, bus.next_node_counter};
    logic [23:0] rec_log [$];
    logic [23:0] prev_rec   = 24'd0;
    logic        prev_stall = 1'b0;
    logic [NW-1:0] last_addr = '0;
    int valid_cnt = 0, done_cnt = 0, stall_cnt = 0, stable_bad = 0;
    int addr_steps = 0, addr_bad = 0;
    always @(posedge clk) begin
        if (bus.out_valid) valid_cnt <= valid_cnt + 1;
        if (bus.out_valid && bus.out_ready) rec_log.push_back(cur_rec);
        if (bus.out_valid && !bus.out_ready) stall_cnt <= stall_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (prev_stall && rst_n && (!bus.out_valid || cur_rec != prev_rec)) stable_bad <= stable_bad + 1;
        prev_stall <= bus.out_valid && !bus.out_ready;
        prev_rec   <= cur_rec;
        if (node_tbl_addr != last_addr) begin
            addr_steps <= addr_steps + 1;
            if (node_tbl_addr != last_addr + 10'd1) addr_bad <= addr_bad + 1;
        end
        last_addr <= node_tbl_addr;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rec(input string tag, input int idx, input logic [23:0] exp);
        check(tag, (idx < rec_log.size()) ? {8'd0, rec_log[idx]} : 32'hFFFF_FFFF, {8'd0, exp});
    endtask

    // Leaves the bench at the negedge just after the start-sampling edge.
    task automatic start_walk(input logic [NW:0] n);
        @(negedge clk);
        num_nodes = n;
        start_run = 1'b1;
        @(negedge clk);
        start_run = 1'b0;
    endtask

    task automatic wait_done(input int n_start, input int budget, output int n_done);
        int n;
        n = n_start;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_done = n;
    endtask

    // Checks the done pulse width and that busy drops right after it.
    task automatic check_done(input string tag, input int n, input int exp_edge);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_done_edge"}, n + 1, exp_edge);
        check({tag, "_busy_at_done"}, busy, 1'b1);
        @(negedge clk);
        check({tag, "_done_fall"}, done, 1'b0);
        check({tag, "_busy_fall"}, busy, 1'b0);
    endtask

    task automatic load_graph_a();
        node_rom[0] = {12'h010, 4'd2};
        node_rom[1] = {12'h020, 4'd0};
        node_rom[2] = {12'h030, 4'd1};
        edge_rom[16] = 10'd5;
        edge_rom[17] = 10'd7;
        edge_rom[48] = 10'd9;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, d0, v0, s0, sb0, a0, ab0;
        rst_n     = 1'b0;
        start_run = 1'b0;
        num_nodes = '0;
        for (int i = 0; i < 1024; i++) node_rom[i] = '0;
        for (int i = 0; i < 4096; i++) edge_rom[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fields", {8'd0, cur_rec}, 32'd0);
        check("rst_addrs", {node_tbl_addr, edge_tbl_addr}, 32'd0);
        rst_n = 1'b1;

        // Test 1: three-node graph, sink always ready.
        load_graph_a();
        ready_fix = 1'b1;
        base = rec_log.size();
        start_walk(11'd3);
        repeat (3) @(negedge clk);
        check("t1_busy", busy, 1'b1);
        check("t1_valid_early", bus.out_valid, 1'b0);
        @(negedge clk);
        check("t1_valid_first", bus.out_valid, 1'b1);
        check("t1_first_fields", {8'd0, cur_rec}, {8'd0, 10'd0, 10'd5, 4'd1});
        wait_done(4, 80, n);
        check_done("t1", n, 17);
        check("t1_count", rec_log.size() - base, 3);
        check_rec("t1_r0", base,     {10'd0, 10'd5, 4'd1});
        check_rec("t1_r1", base + 1, {10'd0, 10'd7, 4'd0});
        check_rec("t1_r2", base + 2, {10'd2, 10'd9, 4'd0});

        // Test 2: same graph, sink ready one cycle in three.
        ready_mode = 1'b1;
        base = rec_log.size();
        s0 = stall_cnt;
        sb0 = stable_bad;
        start_walk(11'd3);
        wait_done(0, 200, n);
        check("t2_done", done, 1'b1);
        @(negedge clk);
        ready_mode = 1'b0;
        check("t2_count", rec_log.size() - base, 3);
        check_rec("t2_r0", base,     {10'd0, 10'd5, 4'd1});
        check_rec("t2_r1", base + 1, {10'd0, 10'd7, 4'd0});
        check_rec("t2_r2", base + 2, {10'd2, 10'd9, 4'd0});
        check("t2_stalls_seen", (stall_cnt - s0) > 0, 1'b1);
        check("t2_stable", stable_bad - sb0, 0);

        // Test 3: empty walk; start held through the finish and done cycles.
        d0 = done_cnt;
        v0 = valid_cnt;
        @(negedge clk);
        num_nodes = 11'd0;
        start_run = 1'b1;
        @(negedge clk);
        check("t3_busy_n0", busy, 1'b1);
        check("t3_done_n0", done, 1'b0);
        @(negedge clk);
        check("t3_done_n1", done, 1'b1);
        check("t3_busy_n1", busy, 1'b1);
        @(negedge clk);
        start_run = 1'b0;
        check("t3_done_n2", done, 1'b0);
        check("t3_busy_n2", busy, 1'b0);
        repeat (4) @(negedge clk);
        check("t3_one_done", done_cnt - d0, 1);
        check("t3_no_valid", valid_cnt - v0, 0);
        check("t3_idle", busy, 1'b0);

        // Test 4: 15 edges starting three entries below the edge-table top.
        node_rom[0] = {12'd4093, 4'd15};
        for (int i = 0; i < 15; i++) edge_rom[(4093 + i) % 4096] = 10'(100 + i);
        ready_fix = 1'b1;
        base = rec_log.size();
        start_walk(11'd1);
        wait_done(0, 200, n);
        check_done("t4", n, 49);
        check("t4_count", rec_log.size() - base, 15);
        for (int i = 0; i < 15; i++)
            check_rec($sformatf("t4_r%0d", i), base + i, {10'd0, 10'(100 + i), 4'(14 - i)});

        // Test 5: asynchronous reset while the second record is stalled.
        load_graph_a();
        ready_fix = 1'b1;
        start_walk(11'd3);
        repeat (6) @(negedge clk);
        ready_fix = 1'b0;
        @(negedge clk);
        check("t5_stalled_valid", bus.out_valid, 1'b1);
        check("t5_stalled_fields", {8'd0, cur_rec}, {8'd0, 10'd0, 10'd7, 4'd0});
        d0 = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", bus.out_valid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_fields", {8'd0, cur_rec}, 32'd0);
        check("t5_rst_addrs", {node_tbl_addr, edge_tbl_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t5_no_done", done_cnt - d0, 0);
        ready_fix = 1'b1;
        base = rec_log.size();
        start_walk(11'd3);
        wait_done(0, 80, n);
        check_done("t5", n, 17);
        check("t5_count", rec_log.size() - base, 3);
        check_rec("t5_r0", base,     {10'd0, 10'd5, 4'd1});
        check_rec("t5_r2", base + 2, {10'd2, 10'd9, 4'd0});

        // Test 6: full 1024-node walk with no edges.
        for (int i = 0; i < 1024; i++) node_rom[i] = '0;
        v0 = valid_cnt;
        start_walk(11'd1024);
        @(negedge clk);
        a0 = addr_steps;
        ab0 = addr_bad;
        wait_done(1, 2300, n);
        check_done("t6", n, 2050);
        check("t6_no_valid", valid_cnt - v0, 0);
        check("t6_addr_steps", addr_steps - a0, 1023);
        check("t6_addr_bad", addr_bad - ab0, 0);
        check("t6_last_addr", node_tbl_addr, 10'd1023);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
